// File: rtl/ysyx_210544_regfile_mp_pkg.sv
// Shared defaults and types for the multi-port register file and its scoreboard.
package ysyx_210544_regfile_mp_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;

  // Where a read port takes its data from in the current cycle.
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ARRAY  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/ysyx_210544_regfile_mp_sb.sv
// Write-back scoreboard: one busy bit per architectural register, allocation
// handshake for the issuing decode slot, release from the write-back ports,
// global flush and a registered count of busy registers.
module ysyx_210544_regfile_mp_sb
  import ysyx_210544_regfile_mp_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int NWR     = NWR_DEF,
  parameter int BYPASS  = 1,
  parameter int ZERO_X0 = 1,
  parameter int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] i_rs_addr,
  input  logic [NRD-1:0]    i_rs_ren,
  output logic [NRD-1:0]    o_rs_busy,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR-1:0]    i_wr_release,
  input  logic              i_alloc_valid,
  input  logic [AW-1:0]     i_alloc_rd,
  output logic              o_alloc_ready,
  input  logic              i_flush,
  output logic [AW:0]       o_busy_cnt
);

  localparam bit ZX = (ZERO_X0 != 0);
  localparam bit BP = (BYPASS != 0);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [NREG-1:0] w_rel_vec;
  logic [AW:0]     r_cnt;
  logic [AW:0]     w_cnt_nxt;
  logic            w_alloc_x0;
  logic            w_alloc_fire;

  // Decode which registers the write-back ports release this cycle.
  always_comb begin
    w_rel_vec = '0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p] && i_wr_release[p]) begin
        w_rel_vec[i_wr_addr[p*AW +: AW]] = 1'b1;
      end
    end
  end

  // Allocating x0 is always accepted but never marks anything busy when x0 is hardwired.
  assign w_alloc_x0    = ZX && (i_alloc_rd == '0);
  assign o_alloc_ready = !i_flush &&
                         (!r_busy[i_alloc_rd] || w_rel_vec[i_alloc_rd] || w_alloc_x0);
  assign w_alloc_fire  = i_alloc_valid && o_alloc_ready && !w_alloc_x0;

  // Next busy vector: release first, then allocation on top so alloc wins, flush overrides all.
  always_comb begin
    w_busy_nxt = r_busy & ~w_rel_vec;
    if (w_alloc_fire) begin
      w_busy_nxt[i_alloc_rd] = 1'b1;
    end
    if (i_flush) begin
      w_busy_nxt = '0;
    end
    if (ZX) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // Population count of the next-state vector so the registered count matches the busy bits after the edge.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
    end
  end

  // Source-operand hazard: a register released this cycle is already free when its data is forwarded.
  always_comb begin
    o_rs_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      o_rs_busy[k] = i_rs_ren[k] &&
                     r_busy[i_rs_addr[k*AW +: AW]] &&
                     !(BP && w_rel_vec[i_rs_addr[k*AW +: AW]]) &&
                     !(ZX && (i_rs_addr[k*AW +: AW] == '0));
    end
  end

  // Busy vector and busy count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/ysyx_210544_regfile_mp.sv
// Multi-port integer register file for a dual-issue core: NRD combinational
// read ports with optional same-cycle forwarding, NWR write ports with
// highest-index priority, a registered debug read port and a scoreboard.
module ysyx_210544_regfile_mp
  import ysyx_210544_regfile_mp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int NWR     = NWR_DEF,
  parameter int BYPASS  = 1,
  parameter int ZERO_X0 = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  input  logic [NRD-1:0]      i_rs_ren,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic [NWR-1:0]      i_wr_release,
  input  logic                i_alloc_valid,
  input  logic [AW-1:0]       i_alloc_rd,
  output logic                o_alloc_ready,
  input  logic                i_flush,
  input  logic [AW-1:0]       i_dbg_addr,
  output logic [XLEN-1:0]     o_dbg_data,
  output logic [AW:0]         o_busy_cnt
);

  localparam bit ZX = (ZERO_X0 != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] r_dbg;

  logic [AW-1:0]   w_rs_addr  [NRD];
  logic [NRD-1:0]  w_fwd_hit;
  logic [XLEN-1:0] w_fwd_data [NRD];
  rd_src_e         w_src      [NRD];

  logic            w_dbg_hit;
  logic [XLEN-1:0] w_dbg_fwd;
  logic [XLEN-1:0] w_dbg_nxt;

  // Array update: ports are visited in ascending order so the highest-index port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (i_wr_en[p] && !(ZX && (i_wr_addr[p*AW +: AW] == '0))) begin
          r_regs[i_wr_addr[p*AW +: AW]] <= i_wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Per read port: find the latest same-cycle write to its address and pick the data source.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      w_rs_addr[k]  = i_rs_addr[k*AW +: AW];
      w_fwd_hit[k]  = 1'b0;
      w_fwd_data[k] = '0;
      for (int p = 0; p < NWR; p++) begin
        if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == w_rs_addr[k])) begin
          w_fwd_hit[k]  = 1'b1;
          w_fwd_data[k] = i_wr_data[p*XLEN +: XLEN];
        end
      end
      if (!i_rs_ren[k] || (ZX && (w_rs_addr[k] == '0))) begin
        w_src[k] = SRC_ZERO;
      end else if (BP && w_fwd_hit[k]) begin
        w_src[k] = SRC_BYPASS;
      end else begin
        w_src[k] = SRC_ARRAY;
      end
    end
  end

  // Read data multiplexer driven by the selected source.
  always_comb begin
    o_rs_data = '0;
    for (int k = 0; k < NRD; k++) begin
      case (w_src[k])
        SRC_BYPASS: o_rs_data[k*XLEN +: XLEN] = w_fwd_data[k];
        SRC_ARRAY:  o_rs_data[k*XLEN +: XLEN] = r_regs[w_rs_addr[k]];
        default:    o_rs_data[k*XLEN +: XLEN] = '0;
      endcase
    end
  end

  // Debug port always sees the post-write value, so it forwards even when read bypass is disabled.
  always_comb begin
    w_dbg_hit = 1'b0;
    w_dbg_fwd = '0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_dbg_addr)) begin
        w_dbg_hit = 1'b1;
        w_dbg_fwd = i_wr_data[p*XLEN +: XLEN];
      end
    end
    if (ZX && (i_dbg_addr == '0)) begin
      w_dbg_nxt = '0;
    end else if (w_dbg_hit) begin
      w_dbg_nxt = w_dbg_fwd;
    end else begin
      w_dbg_nxt = r_regs[i_dbg_addr];
    end
  end

  // Debug data register, one cycle behind the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg <= '0;
    end else begin
      r_dbg <= w_dbg_nxt;
    end
  end

  assign o_dbg_data = r_dbg;

  ysyx_210544_regfile_mp_sb #(
    .NREG    (NREG),
    .NRD     (NRD),
    .NWR     (NWR),
    .BYPASS  (BYPASS),
    .ZERO_X0 (ZERO_X0),
    .AW      (AW)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rs_addr     (i_rs_addr),
    .i_rs_ren      (i_rs_ren),
    .o_rs_busy     (o_rs_busy),
    .i_wr_addr     (i_wr_addr),
    .i_wr_en       (i_wr_en),
    .i_wr_release  (i_wr_release),
    .i_alloc_valid (i_alloc_valid),
    .i_alloc_rd    (i_alloc_rd),
    .o_alloc_ready (o_alloc_ready),
    .i_flush       (i_flush),
    .o_busy_cnt    (o_busy_cnt)
  );

endmodule
